me_wb_pipe: RTL and testbench
=============================

# me_wb_pipe

Parametrised MEM→WB pipeline stage for the rvcpu core, replacing the plain enable-gated register between memory access and write-back. It adds:
- a valid/ready handshake in both directions;
- synchronous flush;
- an optional two-entry skid buffer for full throughput with a registered upstream ready;
- a built-in write-back result mux and x0 write suppression.

It sits between the memory stage and the register-file write port.

## Interface
Parameters:
- XLEN, 64, datapath width of ALU and memory results
- REG_AW, 5, register-index width

Ports:
- clk  in  1  stage clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  synchronous discard of all held entries
- me_valid  in  1  upstream entry valid
- me_ready  out  1  stage can accept an entry
- me_aluOut_WB_memOut  in  1  result select: 1 = memory result, 0 = ALU result
- me_writeReg  in  1  instruction writes rd
- me_outMem  in  XLEN  memory load result
- me_outAlu  in  XLEN  ALU result
- me_rd  in  REG_AW  destination register
- wb_valid  out  1  head entry valid
- wb_ready  in  1  write-back consumes head entry
- wb_aluOut_WB_memOut, wb_writeReg, wb_outMem, wb_outAlu, wb_rd  out  as inputs  head-entry fields
- wb_data  out  XLEN  wb_outMem if wb_aluOut_WB_memOut else wb_outAlu
- wb_we  out  1  wb_valid & wb_writeReg & (wb_rd != 0)
- occupancy  out  2  entries held (0..2)

## Operation
- Transfer in when me_valid & me_ready. Transfer out when wb_valid & wb_ready.
- The payload is all five me_* fields, captured together.
- Reset (rst = 0, asynchronous):
  - all payload registers clear to 0;
  - wb_valid = 0, occupancy = 0, wb_we = 0;
  - me_ready = 1 once rst deasserts (0 during reset).
- Skid state machine (SKID enabled):
  - EMPTY: me_ready = 1. In → ONE.
  - ONE: me_ready = 1.
    - In & out → ONE (main register reloads).
    - In only → TWO (entry lands in skid register).
    - Out only → EMPTY.
  - TWO: me_ready = 0.
    - Out → ONE (skid moves to main).
    - No out → hold.
- Ordering: FIFO. The skid entry is always younger than the main entry.
- Flush:
  - next state EMPTY, wb_valid = 0, occupancy = 0;
  - a transfer presented in the same cycle is dropped;
  - flush takes priority over all other events.
- Payload registers hold their values when no transfer occurs. A stalled head stays stable until consumed.
- A write to register 0 passes through, but wb_we = 0.
- Bubbles (wb_valid = 0) never assert wb_we, whatever the stale fields contain.

## Timing
- Latency: an entry accepted at edge N is presented on wb_* after edge N (one cycle).
- Throughput: one entry per cycle while wb_ready = 1.
- me_ready is a registered output (SKID enabled), derived from state ≠ TWO.
- wb_data and wb_we are combinational from the head registers.
- A reset assertion mid-operation clears state immediately, with no clock required.

## Configuration
- Macro: ME_WB_SKID_EN.
- Defined:
  - two entries as above;
  - me_ready registered;
  - occupancy ranges 0..2.
- Undefined:
  - single register;
  - me_ready = ~wb_valid | wb_ready (combinational path from wb_ready);
  - occupancy ranges 0..1, and bit 1 ties to 0;
  - states reduce to EMPTY/ONE, and ONE with in & out stays ONE.
- Both builds must give identical wb_* sequences for identical accepted inputs.

## Structure
- Shared package rvcpu_pkg holds:
  - XLEN and REG_AW defaults;
  - the me_wb payload struct (sel, writeReg, outMem, outAlu, rd) and its packed width constant;
  - the state encoding EMPTY/ONE/TWO.
- One sub-module: pipe_skid_buf. It is a generic payload-width valid/ready two-entry buffer with flush and occupancy.
- me_wb_pipe packs and unpacks the payload and adds the wb_data and wb_we logic.

## Test plan
- **Reset:** hold rst = 0 with random inputs. Require wb_valid = 0, wb_we = 0, occupancy = 0, and all wb_* fields = 0. Release rst, and me_ready = 1 on the next cycle.
- **Streaming:** wb_ready = 1; enter 8 back-to-back entries with outAlu = i and rd = i+1, select = 0. Require wb_data = i one cycle after each accept, wb_we = 1 for each, and no stall cycles.
- **Backpressure:** wb_ready = 0 while entries A and B enter. Require occupancy = 2, me_ready = 0, and A held stable. Set wb_ready = 1: A then B appear in order, and me_ready returns to 1 one cycle after A leaves.
- **Mux and x0:**
  - select = 1, outMem = 0xDEAD, outAlu = 0xBEEF → wb_data = 0xDEAD;
  - rd = 0 with writeReg = 1 → wb_we = 0 while wb_valid = 1.
- **Flush:** with occupancy = 2, assert flush together with a new me_valid. Next cycle: occupancy = 0 and wb_valid = 0, and the new entry never appears.
- **Build equivalence:** run the same random valid/ready stimulus with and without ME_WB_SKID_EN. Require identical output entry streams.

Source files
------------

// File: rtl/rvcpu_pkg.sv
// rvcpu_pkg: shared definitions for the rvcpu MEM->WB pipeline stage.
//   XLEN_DEF / REG_AW_DEF : default datapath and register-index widths
//   me_wb_t               : MEM->WB payload layout (sel, write_reg, out_mem, out_alu, rd)
//   ME_WB_W               : packed width of me_wb_t at the default widths
//   pipe_state_e          : occupancy state encoding of the stage buffer
//   me_wb_width()         : packed payload width for arbitrary widths
package rvcpu_pkg;

   localparam int unsigned XLEN_DEF   = 64;
   localparam int unsigned REG_AW_DEF = 5;

   // Field order is MSB first; the top packs its flat vector in the same order.
   typedef struct packed {
      logic                  sel;
      logic                  write_reg;
      logic [XLEN_DEF-1:0]   out_mem;
      logic [XLEN_DEF-1:0]   out_alu;
      logic [REG_AW_DEF-1:0] rd;
   } me_wb_t;

   localparam int unsigned ME_WB_W = $bits(me_wb_t);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   function automatic int unsigned me_wb_width(input int unsigned xlen,
                                               input int unsigned aw);
      return 32'd2 + 32'd2 * xlen + aw;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready pipeline buffer with flush and occupancy.
//   Build option ME_WB_SKID_EN:
//     defined   - two entries (main + skid), registered in_ready, occupancy 0..2
//     undefined - single register, in_ready = ~out_valid | out_ready, occupancy 0..1
// Ports:
//   clk, rst (async active-low), flush (sync discard of held entries)
//   in_valid/in_ready/in_data    : upstream side
//   out_valid/out_ready/out_data : downstream side, out_data is the head entry
//   occupancy                    : number of held entries
module pipe_skid_buf
   import rvcpu_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);

   pipe_state_e  state;
   logic [W-1:0] main_q;
   logic         in_fire;
   logic         out_fire;

`ifdef ME_WB_SKID_EN

   logic [W-1:0] skid_q;
   logic         ready_q;
   logic         valid_q;
   logic [1:0]   occ_q;

   assign in_fire  = in_valid & ready_q;
   assign out_fire = valid_q & out_ready;

   // Control outputs are registered next to the state so in_ready has no
   // combinational path from out_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= EMPTY;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         occ_q   <= 2'd0;
      end else if (flush) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         occ_q   <= 2'd0;
      end else begin
         case (state)
            EMPTY: begin
               ready_q <= 1'b1;
               if (in_fire) begin
                  state   <= ONE;
                  valid_q <= 1'b1;
                  occ_q   <= 2'd1;
               end
            end
            ONE: begin
               if (in_fire && !out_fire) begin
                  state   <= TWO;
                  ready_q <= 1'b0;
                  occ_q   <= 2'd2;
               end else if (!in_fire && out_fire) begin
                  state   <= EMPTY;
                  ready_q <= 1'b1;
                  valid_q <= 1'b0;
                  occ_q   <= 2'd0;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state   <= ONE;
                  ready_q <= 1'b1;
                  occ_q   <= 2'd1;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
               occ_q   <= 2'd0;
            end
         endcase
      end
   end

   // Skid always holds the younger entry; it moves to main when main drains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (!flush) begin
         case (state)
            EMPTY: if (in_fire) main_q <= in_data;
            ONE: begin
               if (in_fire && out_fire) main_q <= in_data;
               else if (in_fire)        skid_q <= in_data;
            end
            TWO: if (out_fire) main_q <= skid_q;
            default: ;
         endcase
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = valid_q;
   assign occupancy = occ_q;

`else

   logic run_q;

   assign out_valid = (state == ONE);
   // run_q keeps in_ready low while reset is asserted.
   assign in_ready  = run_q & (~out_valid | out_ready);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (flush)         state <= EMPTY;
         else if (in_fire)  state <= ONE;
         else if (out_fire) state <= EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  main_q <= '0;
      else if (!flush && in_fire) main_q <= in_data;
   end

   assign occupancy = {1'b0, out_valid};

`endif

   assign out_data = main_q;

endmodule

// File: rtl/me_wb_pipe.sv
// me_wb_pipe: MEM->WB pipeline stage for the rvcpu core.
//   Build option ME_WB_SKID_EN selects the two-entry skid buffer (registered
//   me_ready); otherwise a single register with combinational me_ready.
// Ports:
//   clk, rst (async active-low), flush (sync discard)
//   me_* : upstream entry (valid/ready + sel, writeReg, outMem, outAlu, rd)
//   wb_* : head entry (valid/ready + same fields), wb_data (selected result),
//          wb_we (register-file write enable, suppressed for x0 and bubbles)
//   occupancy : entries held
module me_wb_pipe
   import rvcpu_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              me_valid,
   output logic              me_ready,
   input  logic              me_aluOut_WB_memOut,
   input  logic              me_writeReg,
   input  logic [XLEN-1:0]   me_outMem,
   input  logic [XLEN-1:0]   me_outAlu,
   input  logic [REG_AW-1:0] me_rd,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_aluOut_WB_memOut,
   output logic              wb_writeReg,
   output logic [XLEN-1:0]   wb_outMem,
   output logic [XLEN-1:0]   wb_outAlu,
   output logic [REG_AW-1:0] wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_we,
   output logic [1:0]        occupancy
);

   localparam int unsigned PW = me_wb_width(XLEN, REG_AW);

   logic [PW-1:0] in_data;
   logic [PW-1:0] out_data;

   // Same field order as me_wb_t.
   assign in_data = {me_aluOut_WB_memOut, me_writeReg, me_outMem, me_outAlu, me_rd};
   assign {wb_aluOut_WB_memOut, wb_writeReg, wb_outMem, wb_outAlu, wb_rd} = out_data;

   pipe_skid_buf #(.W(PW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (me_valid),
      .in_ready  (me_ready),
      .in_data   (in_data),
      .out_valid (wb_valid),
      .out_ready (wb_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   assign wb_data = wb_aluOut_WB_memOut ? wb_outMem : wb_outAlu;
   assign wb_we   = wb_valid & wb_writeReg & (wb_rd != '0);

endmodule

// File: tb/tb_me_wb_pipe.sv
module tb_me_wb_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, me_valid, me_ready;
   logic        me_sel, me_wr;
   logic [63:0] me_mem, me_alu;
   logic [4:0]  me_rd;
   logic        wb_valid, wb_ready, wb_sel, wb_wr, wb_we;
   logic [63:0] wb_mem, wb_alu, wb_data;
   logic [4:0]  wb_rd;
   logic [1:0]  occupancy;

   always #5 clk = ~clk;

   me_wb_pipe #(.XLEN(64), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .me_valid(me_valid), .me_ready(me_ready),
      .me_aluOut_WB_memOut(me_sel), .me_writeReg(me_wr),
      .me_outMem(me_mem), .me_outAlu(me_alu), .me_rd(me_rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_aluOut_WB_memOut(wb_sel), .wb_writeReg(wb_wr),
      .wb_outMem(wb_mem), .wb_outAlu(wb_alu), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_we(wb_we), .occupancy(occupancy)
   );

   typedef struct {
      logic        sel;
      logic        wr;
      logic [63:0] mem;
      logic [63:0] alu;
      logic [4:0]  rd;
   } ent_t;

   // Reference model: FIFO of entries held by the stage.
   ent_t mq[$];
   bit   started;
   int   tests = 0;
   int   fails = 0;

`ifdef ME_WB_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_ready(input logic rdy);
      if (!started) return 1'b0;
      if (SKID) return mq.size() < 2;
      return (mq.size() == 0) || rdy;
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.sel = 1'($urandom);
      e.wr  = 1'($urandom);
      e.mem = {$urandom, $urandom};
      e.alu = {$urandom, $urandom};
      e.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      return e;
   endfunction

   function automatic ent_t mk_ent(input logic sel, input logic wr, input logic [63:0] mem,
                                   input logic [63:0] alu, input logic [4:0] rd);
      ent_t e;
      e.sel = sel; e.wr = wr; e.mem = mem; e.alu = alu; e.rd = rd;
      return e;
   endfunction

   task automatic check_outputs(input string ph, input logic rdy);
      chk({ph, ".wb_valid"}, 64'(wb_valid), 64'(mq.size() > 0));
      chk({ph, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
      chk({ph, ".me_ready"}, 64'(me_ready), 64'(model_ready(rdy)));
      if (mq.size() > 0) begin
         chk({ph, ".wb_sel"}, 64'(wb_sel), 64'(mq[0].sel));
         chk({ph, ".wb_wr"}, 64'(wb_wr), 64'(mq[0].wr));
         chk({ph, ".wb_mem"}, wb_mem, mq[0].mem);
         chk({ph, ".wb_alu"}, wb_alu, mq[0].alu);
         chk({ph, ".wb_rd"}, 64'(wb_rd), 64'(mq[0].rd));
         chk({ph, ".wb_data"}, wb_data, mq[0].sel ? mq[0].mem : mq[0].alu);
         chk({ph, ".wb_we"}, 64'(wb_we), 64'(mq[0].wr && (mq[0].rd != 5'd0)));
      end else begin
         chk({ph, ".wb_we_bubble"}, 64'(wb_we), 64'd0);
      end
   endtask

   // Entered at posedge+1; drives inputs, checks at posedge+4, advances the model.
   task automatic step(input logic v, input ent_t e, input logic rdy, input logic fl, input string ph);
      logic mr, in_f, out_f;
      me_valid = v; me_sel = e.sel; me_wr = e.wr; me_mem = e.mem; me_alu = e.alu; me_rd = e.rd;
      wb_ready = rdy; flush = fl;
      #3;
      check_outputs(ph, rdy);
      mr    = model_ready(rdy);
      in_f  = v & mr;
      out_f = (mq.size() > 0) & rdy;
      @(posedge clk);
      if (rst === 1'b0) begin
         mq.delete();
         started = 1'b0;
      end else begin
         if (fl) mq.delete();
         else begin
            if (out_f) void'(mq.pop_front());
            if (in_f)  mq.push_back(e);
         end
         started = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input logic rdy, input string ph);
      step(1'b0, rand_ent(), rdy, 1'b0, ph);
   endtask

   task automatic check_zero_fields(input string ph);
      chk({ph, ".wb_valid"}, 64'(wb_valid), 64'd0);
      chk({ph, ".wb_we"}, 64'(wb_we), 64'd0);
      chk({ph, ".occupancy"}, 64'(occupancy), 64'd0);
      chk({ph, ".wb_sel"}, 64'(wb_sel), 64'd0);
      chk({ph, ".wb_wr"}, 64'(wb_wr), 64'd0);
      chk({ph, ".wb_mem"}, wb_mem, 64'd0);
      chk({ph, ".wb_alu"}, wb_alu, 64'd0);
      chk({ph, ".wb_rd"}, 64'(wb_rd), 64'd0);
   endtask

   initial begin
      ent_t e;
      rst = 1'b0; flush = 1'b0; me_valid = 1'b0; wb_ready = 1'b0;
      me_sel = 1'b0; me_wr = 1'b0; me_mem = '0; me_alu = '0; me_rd = '0;
      started = 1'b0;
      @(posedge clk); #1;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom), rand_ent(), 1'($urandom), 1'b0, "reset");
         check_zero_fields("reset_hold");
      end
      rst = 1'b1;
      idle(1'b0, "rst_release");
      chk("ready_after_release", 64'(me_ready), 64'd1);

      // Streaming: 8 back-to-back entries
      for (int i = 0; i < 8; i++) begin
         step(1'b1, mk_ent(1'b0, 1'b1, {$urandom, $urandom}, 64'(i), 5'(i + 1)), 1'b1, 1'b0, "stream");
         chk("stream_data", wb_data, 64'(i));
         chk("stream_we", 64'(wb_we), 64'd1);
      end
      idle(1'b1, "stream_drain");
      idle(1'b1, "stream_drain");

      // Backpressure
      step(1'b1, mk_ent(1'b0, 1'b1, 64'h0, 64'hA, 5'd4), 1'b0, 1'b0, "bp_a");
      step(1'b1, mk_ent(1'b0, 1'b1, 64'h0, 64'hB, 5'd5), 1'b0, 1'b0, "bp_b");
      if (SKID) begin
         chk("bp_occupancy2", 64'(occupancy), 64'd2);
         chk("bp_ready_low", 64'(me_ready), 64'd0);
      end
      chk("bp_head_a", wb_data, 64'hA);
      idle(1'b0, "bp_hold");
      chk("bp_head_stable", wb_data, 64'hA);
      idle(1'b1, "bp_release");
      if (SKID) chk("bp_ready_back", 64'(me_ready), 64'd1);
      idle(1'b1, "bp_drain");
      idle(1'b1, "bp_drain");

      // Mux and x0
      step(1'b1, mk_ent(1'b1, 1'b1, 64'hDEAD, 64'hBEEF, 5'd3), 1'b1, 1'b0, "mux");
      chk("mux_mem", wb_data, 64'hDEAD);
      step(1'b1, mk_ent(1'b0, 1'b1, 64'h1, 64'h2, 5'd0), 1'b1, 1'b0, "x0");
      chk("x0_valid", 64'(wb_valid), 64'd1);
      chk("x0_we", 64'(wb_we), 64'd0);
      idle(1'b1, "x0_drain");

      // Flush with a concurrent transfer
      step(1'b1, rand_ent(), 1'b0, 1'b0, "fl_fill");
      step(1'b1, rand_ent(), 1'b0, 1'b0, "fl_fill");
      step(1'b1, mk_ent(1'b0, 1'b1, 64'h0, 64'hF1, 5'd7), 1'b0, 1'b1, "flush");
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_valid", 64'(wb_valid), 64'd0);
      idle(1'b1, "post_flush");
      idle(1'b1, "post_flush");

      // Asynchronous reset mid-operation
      step(1'b1, rand_ent(), 1'b0, 1'b0, "arst_fill");
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 64'(wb_valid), 64'd0);
      chk("arst_occ", 64'(occupancy), 64'd0);
      mq.delete(); started = 1'b0;
      @(posedge clk); #1;
      check_zero_fields("arst_fields");
      rst = 1'b1;
      idle(1'b1, "arst_release");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         e = rand_ent();
         step(($urandom_range(0, 9) < 7), e, ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 31) == 0), "rand");
      end
      for (int i = 0; i < 4; i++) idle(1'b1, "final_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
